qpsk_tx_sequencer: RTL and testbench
====================================

# qpsk_tx_sequencer

Frame-level controller that drives the `qpsk_modulator` symbol interface. On `start` it latches a carrier FCW and a payload length. It then feeds the modulator one dibit per `mod_req`: a preamble, a 16-bit sync word, the payload bytes pulled from an upstream byte stream, and finally tail symbols. It sits between the packet/DMA front end and the modulator, owning `symbol_in`, `symbol_en` and `fcw`.

## Interface
Parameters:
- `PREAMBLE_SYMS`, 16, preamble length in symbols (≥1).
- `SYNC_WORD`, 16'hF35A, sync word sent MSB dibit first (8 symbols).
- `TAIL_SYMS`, 4, trailing pad symbols (0 = none).

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle frame request; ignored while `busy`.
- `len_in` in 16: payload length in bytes, sampled on accepted `start`.
- `fcw_in` in 32: carrier FCW, sampled on accepted `start`.
- `byte_data` in 8: payload byte.
- `byte_valid` in 1: `byte_data` valid.
- `byte_ready` out 1: sequencer takes a byte this cycle.
- `mod_req` in 1: modulator request for the next symbol.
- `symbol_out` out 2: to modulator `symbol_in`.
- `symbol_en` out 1: to modulator `symbol_en`.
- `fcw_out` out 32: to modulator `fcw`.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at frame end.
- `underrun` out 1: sticky; a payload byte was missing when needed. Cleared on the next accepted `start`.

## Operation
- States: IDLE, PREAMBLE, SYNC, PAYLOAD, TAIL.
- IDLE → PREAMBLE on `start`.
  - Latch `len_in` and `fcw_in`; clear `underrun`.
  - Load first preamble symbol; set `busy` and `symbol_en`.
- PREAMBLE: symbols alternate 2'b00, 2'b11, starting with 00. After `PREAMBLE_SYMS` symbols → SYNC.
- SYNC: 8 dibits of `SYNC_WORD`, MSB first. On the last one:
  - go to PAYLOAD if len>0;
  - else go to TAIL if `TAIL_SYMS`>0;
  - else end the frame.
- PAYLOAD: each byte gives 4 dibits, MSB first ([7:6], [5:4], [3:2], [1:0]).
  - A byte is loaded when the current symbol is the last sync dibit or dibit [1:0] of a byte, and bytes remain.
  - Missing byte (`byte_valid`=0 at that point): send 8'h00 in its place and set `underrun`. The byte count still advances.
  - After the last dibit of byte len → TAIL, or end the frame if `TAIL_SYMS`=0.
- TAIL: `TAIL_SYMS` symbols of 2'b00, then end the frame.
- Frame end → IDLE:
  - `symbol_en`=0, `busy`=0, `done`=1 for one cycle.
  - `symbol_out` resets to 00; `fcw_out` keeps its last value.
- Advance rule: a symbol is consumed only on a cycle with `mod_req`=1 in a non-IDLE state. `mod_req` in IDLE is ignored.
- Symbols per frame = `PREAMBLE_SYMS` + 8 + 4·len + `TAIL_SYMS`.

## Timing
- Reset values: `symbol_out`=0, `symbol_en`=0, `fcw_out`=0, `busy`=0, `done`=0, `underrun`=0, `byte_ready`=0; state IDLE.
- `start` accepted at edge N:
  - from N+1: first symbol on `symbol_out`, `symbol_en`=1, `busy`=1, `fcw_out` valid.
- `mod_req` high in cycle k: next symbol appears on `symbol_out` at k+1 (registered).
- `byte_ready` is combinational: = `mod_req` ∧ (byte-load condition above).
  - Transfer happens when `byte_valid` ∧ `byte_ready` in the same cycle.
  - The byte's first dibit appears at k+1.
- `done` is high the cycle after the final consumed `mod_req`. A `start` in that same cycle is accepted.
- `start` and the final `mod_req` in the same cycle: `start` is ignored.
- `reset` mid-frame: back to IDLE next edge with all outputs at reset values; no `done` pulse.
- Counters:
  - preamble/tail counters: $clog2(max(PREAMBLE_SYMS, TAIL_SYMS)+1) bits;
  - byte counter: 16 bits;
  - dibit index: 2 bits, wraps 3→0.

## Structure
- Package `qpsk_tx_pkg`:
  - `tx_state_t` enum;
  - `symbol_t` (logic [1:0]);
  - `PAD_SYMBOL`=2'b00;
  - preamble symbol pair;
  - default `SYNC_WORD`.
- Sub-module `qpsk_dibit_serializer`:
  - 8-bit load and shift, MSB dibit out;
  - used for both payload bytes and the two sync bytes.
- FSM and counters live in the top level.

## Test plan
- Defaults, len=2, bytes 0xC6 then 0x1B, `mod_req` every 100 cycles.
  - Expect 36 symbols: 00,11 ×8; then 11,11,00,11,01,01,10,10; then 11,00,01,10,00,01,10,11; then 00 ×4.
  - Expect `done` one cycle after the 36th `mod_req`; `fcw_out`=42949673 throughout.
- len=0: expect 16+8+4=28 symbols, `byte_ready` never asserted, `done` pulses.
- len=1, `byte_valid`=0 at load:
  - expect dibits 00,00,00,00 in the payload and `underrun`=1 after the frame;
  - `underrun` clears on the next `start`.
- `start` pulsed while `busy` with `len_in`=5: expect it ignored and the current frame's length unchanged.
- `reset` asserted mid-PAYLOAD: expect `symbol_en`=0 and `busy`=0 next cycle, no `done`; a new `start` produces the preamble again.
- `TAIL_SYMS`=0, `mod_req` held high continuously: one symbol per cycle; `done` immediately after the last payload dibit.

Source files
------------

// File: rtl/qpsk_tx_pkg.sv
// Shared types and constants for the QPSK frame sequencer.
// States, symbol type, pad/preamble symbols and default sync word.
package qpsk_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_TAIL
  } tx_state_t;

  typedef logic [1:0] symbol_t;

  localparam symbol_t PAD_SYMBOL = 2'b00;
  localparam symbol_t PRE_SYM_A  = 2'b00;
  localparam symbol_t PRE_SYM_B  = 2'b11;

  localparam logic [15:0] DEF_SYNC_WORD = 16'hF35A;

  function automatic symbol_t pre_toggle(input symbol_t s);
    return (s == PRE_SYM_A) ? PRE_SYM_B : PRE_SYM_A;
  endfunction

endpackage

// File: rtl/qpsk_dibit_serializer.sv
// Byte to dibit shifter, MSB dibit first; feeds sync and payload.
// Ports: clk, reset, load/din, shift; dout_next = top dibit after edge.
module qpsk_dibit_serializer
  import qpsk_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output symbol_t    dout_next
);

  logic [7:0] sr_q;
  logic [7:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {sr_q[5:0], 2'b00};
    end
  end

  // Lets the top register the upcoming symbol in the same edge.
  assign dout_next = sr_d[7:6];

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/qpsk_tx_sequencer.sv
// Frame sequencer: preamble, sync word, payload bytes, tail to modulator.
// Ports: start/len_in/fcw_in, byte stream in, mod_req in, symbol/status out.
module qpsk_tx_sequencer
  import qpsk_tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_SYMS = 16,
  parameter logic [15:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int unsigned TAIL_SYMS     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] len_in,
  input  logic [31:0] fcw_in,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        mod_req,
  output logic [1:0]  symbol_out,
  output logic        symbol_en,
  output logic [31:0] fcw_out,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int unsigned CNT_MAX =
    (PREAMBLE_SYMS > TAIL_SYMS) ? PREAMBLE_SYMS : TAIL_SYMS;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_SYMS - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST =
    (TAIL_SYMS > 0) ? CNT_W'(TAIL_SYMS - 1) : '0;
  localparam bit HAS_TAIL = (TAIL_SYMS > 0);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      byte_cnt_q, byte_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             sync_lo_q, sync_lo_d;
  logic [15:0]      len_q, len_d;
  logic [31:0]      fcw_q, fcw_d;
  symbol_t          sym_q, sym_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             und_q, und_d;

  logic       adv;
  logic       last_dibit;
  logic       bytes_left;
  logic       load_cond;
  logic [7:0] byte_in;
  logic       end_frame;
  logic       ser_load;
  logic       ser_shift;
  logic [7:0] ser_din;
  symbol_t    ser_next;
  logic       sym_sel;
  symbol_t    sym_fsm;

  assign adv        = mod_req && (state_q != ST_IDLE);
  assign last_dibit = (idx_q == 2'd3);
  assign bytes_left = (byte_cnt_q != len_q);
  // byte_cnt is zero through sync, so the last sync dibit loads iff len>0.
  assign load_cond  = last_dibit && bytes_left &&
                      ((state_q == ST_SYNC && sync_lo_q) ||
                       (state_q == ST_PAYLOAD));
  assign byte_ready = mod_req && load_cond;
  assign byte_in    = byte_valid ? byte_data : 8'h00;

  qpsk_dibit_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .shift     (ser_shift),
    .din       (ser_din),
    .dout_next (ser_next)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    idx_d      = idx_q;
    sync_lo_d  = sync_lo_q;
    len_d      = len_q;
    fcw_d      = fcw_q;
    sym_fsm    = sym_q;
    sym_sel    = 1'b0;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    und_d      = und_q;
    end_frame  = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    ser_din    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PREAMBLE;
          len_d      = len_in;
          fcw_d      = fcw_in;
          und_d      = 1'b0;
          cnt_d      = '0;
          byte_cnt_d = '0;
          sym_fsm    = PRE_SYM_A;
          en_d       = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (adv) begin
          if (cnt_q == PRE_LAST) begin
            state_d   = ST_SYNC;
            idx_d     = '0;
            sync_lo_d = 1'b0;
            ser_load  = 1'b1;
            ser_din   = SYNC_WORD[15:8];
            sym_sel   = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            sym_fsm = pre_toggle(sym_q);
          end
        end
      end
      ST_SYNC, ST_PAYLOAD: begin
        if (adv) begin
          if (!last_dibit) begin
            ser_shift = 1'b1;
            idx_d     = idx_q + 2'd1;
            sym_sel   = 1'b1;
          end else if (state_q == ST_SYNC && !sync_lo_q) begin
            ser_load  = 1'b1;
            ser_din   = SYNC_WORD[7:0];
            sync_lo_d = 1'b1;
            idx_d     = '0;
            sym_sel   = 1'b1;
          end else if (bytes_left) begin
            state_d    = ST_PAYLOAD;
            ser_load   = 1'b1;
            ser_din    = byte_in;
            idx_d      = '0;
            byte_cnt_d = byte_cnt_q + 16'd1;
            sym_sel    = 1'b1;
            if (!byte_valid) begin
              und_d = 1'b1;
            end
          end else if (HAS_TAIL) begin
            state_d = ST_TAIL;
            cnt_d   = '0;
            sym_fsm = PAD_SYMBOL;
          end else begin
            end_frame = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (adv) begin
          if (cnt_q == TAIL_LAST) begin
            end_frame = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_frame) begin
      state_d = ST_IDLE;
      sym_fsm = PAD_SYMBOL;
      sym_sel = 1'b0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  assign sym_d = sym_sel ? ser_next : sym_fsm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      idx_q      <= '0;
      sync_lo_q  <= 1'b0;
      len_q      <= '0;
      fcw_q      <= '0;
      sym_q      <= PAD_SYMBOL;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      idx_q      <= idx_d;
      sync_lo_q  <= sync_lo_d;
      len_q      <= len_d;
      fcw_q      <= fcw_d;
      sym_q      <= sym_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      und_q      <= und_d;
    end
  end

  assign symbol_out = sym_q;
  assign symbol_en  = en_q;
  assign fcw_out    = fcw_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_qpsk_tx_sequencer.sv
// Random-stimulus bench for qpsk_tx_sequencer against a frame-level model.
// Two instances: default params, and a short preamble with no tail.
module tb_qpsk_tx_sequencer;

  localparam int P0 = 16;
  localparam int T0 = 4;
  localparam int P1 = 3;
  localparam int T1 = 0;
  localparam logic [15:0] SW = 16'hF35A;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len_in;
  logic [31:0] fcw_in;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        mod_req;

  logic        byte_ready [2];
  logic [1:0]  symbol_out [2];
  logic        symbol_en  [2];
  logic [31:0] fcw_out    [2];
  logic        busy       [2];
  logic        done       [2];
  logic        underrun   [2];

  always #5 clk = ~clk;

  qpsk_tx_sequencer u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len_in     (len_in),
    .fcw_in     (fcw_in),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready[0]),
    .mod_req    (mod_req),
    .symbol_out (symbol_out[0]),
    .symbol_en  (symbol_en[0]),
    .fcw_out    (fcw_out[0]),
    .busy       (busy[0]),
    .done       (done[0]),
    .underrun   (underrun[0])
  );

  qpsk_tx_sequencer #(
    .PREAMBLE_SYMS (P1),
    .TAIL_SYMS     (T1)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len_in     (len_in),
    .fcw_in     (fcw_in),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready[1]),
    .mod_req    (mod_req),
    .symbol_out (symbol_out[1]),
    .symbol_en  (symbol_en[1]),
    .fcw_out    (fcw_out[1]),
    .busy       (busy[1]),
    .done       (done[1]),
    .underrun   (underrun[1])
  );

  int mp [2] = '{P0, P1};
  int mt [2] = '{T0, T1};

  bit          m_act  [2];
  int          m_k    [2];
  int          m_n    [2];
  int          m_len  [2];
  logic [7:0]  m_pay  [2][16];
  logic [1:0]  m_sym  [2];
  logic        m_en   [2];
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_und  [2];
  logic [31:0] m_fcw  [2];

  int n_chk  = 0;
  int n_pass = 0;

  bit         rec_on = 1'b0;
  logic [1:0] rec [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] sym_at(input int i, input int k);
    int q;
    if (k < mp[i]) return (k % 2 == 1) ? 2'b11 : 2'b00;
    q = k - mp[i];
    if (q < 8) return 2'(SW >> (14 - 2 * q));
    q = q - 8;
    if (q < 4 * m_len[i]) return 2'(m_pay[i][q / 4] >> (6 - 2 * (q % 4)));
    return 2'b00;
  endfunction

  function automatic bit is_load(input int i, input int k);
    int q;
    q = k - (mp[i] + 7);
    return (q >= 0) && (q % 4 == 0) && (q / 4 < m_len[i]);
  endfunction

  task automatic model_reset(input int i);
    m_act[i]  = 1'b0;
    m_k[i]    = 0;
    m_sym[i]  = 2'b00;
    m_en[i]   = 1'b0;
    m_busy[i] = 1'b0;
    m_done[i] = 1'b0;
    m_und[i]  = 1'b0;
    m_fcw[i]  = '0;
  endtask

  task automatic step(input bit st, input bit mr, input bit bv,
                      input logic [7:0] bd, input logic [15:0] ln,
                      input logic [31:0] fc, input bit rs);
    int j;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("sym%0d", i), 32'(symbol_out[i]), 32'(m_sym[i]));
      check($sformatf("en%0d", i), 32'(symbol_en[i]), 32'(m_en[i]));
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_busy[i]));
      check($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
      check($sformatf("und%0d", i), 32'(underrun[i]), 32'(m_und[i]));
      check($sformatf("fcw%0d", i), fcw_out[i], m_fcw[i]);
    end
    reset      = rs;
    start      = st;
    mod_req    = mr;
    byte_valid = bv;
    byte_data  = bd;
    len_in     = ln;
    fcw_in     = fc;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rdy%0d", i), 32'(byte_ready[i]),
            32'(m_act[i] && mr && is_load(i, m_k[i])));
    end
    if (rec_on && mr && m_act[0]) rec.push_back(symbol_out[0]);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (rs) begin
        model_reset(i);
      end else if (m_act[i]) begin
        if (mr) begin
          if (is_load(i, m_k[i])) begin
            j = (m_k[i] - mp[i] - 7) / 4;
            m_pay[i][j] = bv ? bd : 8'h00;
            if (!bv) m_und[i] = 1'b1;
          end
          m_k[i]++;
          if (m_k[i] == m_n[i]) begin
            m_act[i]  = 1'b0;
            m_sym[i]  = 2'b00;
            m_en[i]   = 1'b0;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end else begin
            m_sym[i] = sym_at(i, m_k[i]);
          end
        end
      end else if (st) begin
        m_act[i]  = 1'b1;
        m_k[i]    = 0;
        m_len[i]  = int'(ln);
        m_fcw[i]  = fc;
        m_und[i]  = 1'b0;
        m_n[i]    = mp[i] + 8 + 4 * int'(ln) + mt[i];
        m_sym[i]  = sym_at(i, 0);
        m_en[i]   = 1'b1;
        m_busy[i] = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  task automatic run_frame(input int ln, input logic [31:0] fc,
                           input int mr_period, input int mr_pct,
                           input int bv_pct, input int st_pct,
                           input bit pat, input bit ign);
    int         cyc;
    bit         mr;
    bit         bv;
    bit         st;
    logic [7:0] bd;
    logic [15:0] sl;
    cyc = 0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 16'(ln), fc, 1'b0);
    while ((m_act[0] || m_act[1]) && cyc < 20000) begin
      if (mr_period > 0) mr = (cyc % mr_period == mr_period - 1);
      else mr = ($urandom_range(99) < mr_pct);
      bv = ($urandom_range(99) < bv_pct);
      st = ($urandom_range(99) < st_pct);
      sl = 16'($urandom_range(6));
      if (ign && cyc == 5) begin
        st = 1'b1;
        sl = 16'd5;
      end
      if (pat) bd = (m_k[0] < P0 + 8) ? 8'hC6 : 8'h1B;
      else bd = 8'($urandom);
      step(st, mr, bv, bd, sl, $urandom, 1'b0);
      cyc++;
    end
    if (cyc >= 20000) check("timeout", 32'd0, 32'd1);
  endtask

  logic [1:0] tab_a [36];
  logic [1:0] tab_mid [20];

  initial begin
    int c;
    reset      = 1'b1;
    start      = 1'b0;
    mod_req    = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    len_in     = '0;
    fcw_in     = '0;
    for (int i = 0; i < 2; i++) model_reset(i);
    repeat (2) @(posedge clk);

    step(1'b0, 1'b1, 1'b0, 8'h00, 16'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h55, 16'd3, 32'd7, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 32'd0, 1'b0);

    tab_mid = '{2'd3, 2'd3, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2,
                2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3,
                2'd0, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 16; i++) tab_a[i] = (i % 2 == 1) ? 2'd3 : 2'd0;
    for (int i = 0; i < 20; i++) tab_a[16 + i] = tab_mid[i];

    rec_on = 1'b1;
    run_frame(2, 32'd42949673, 100, 0, 100, 0, 1'b1, 1'b0);
    rec_on = 1'b0;
    check("frameA_len", 32'(rec.size()), 32'd36);
    for (int i = 0; i < 36 && i < rec.size(); i++) begin
      check($sformatf("frameA_sym%0d", i), 32'(rec[i]), 32'(tab_a[i]));
    end

    run_frame(0, $urandom, 0, 50, 100, 0, 1'b0, 1'b0);

    run_frame(1, $urandom, 0, 60, 0, 0, 1'b0, 1'b0);
    #1;
    check("und_after0", 32'(underrun[0]), 32'd1);
    check("und_after1", 32'(underrun[1]), 32'd1);

    run_frame(3, $urandom, 0, 70, 90, 0, 1'b0, 1'b1);

    step(1'b1, 1'b0, 1'b0, 8'h00, 16'd4, 32'h1234_5678, 1'b0);
    c = 0;
    while (m_k[0] <= P0 + 9 && c < 500) begin
      step(1'b0, 1'b1, 1'b1, 8'($urandom), 16'd0, 32'd0, 1'b0);
      c++;
    end
    if (c >= 500) check("timeout_mid", 32'd0, 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 16'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 32'd0, 1'b0);
    run_frame(2, $urandom, 0, 100, 100, 0, 1'b0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      run_frame($urandom_range(6), $urandom, 0, $urandom_range(20, 100),
                $urandom_range(50, 100), 3, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
